// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_pkg
// Brief    : Shared types and constants for the USB full-speed transmitter:
//            state encoding, line codes and CRC16 constants.
//            Optional feature macro: USB_TX_CRC16_EN.
// Revision : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

   // Transmitter phases; ST_CRC is only reachable when the CRC16 option is built in
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_DATA    = 3'd2,
      ST_CRC     = 3'd3,
      ST_EOP_SE0 = 3'd4,
      ST_EOP_J   = 3'd5
   } tx_state_t;

   // Line codes as {d_plus, d_minus}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   // USB data CRC: x^16 + x^15 + x^2 + 1, preset to all ones
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // Bit-reverse a 16-bit word; lets the CRC run LSB-first as a right shift
   function automatic logic [15:0] reflect16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i] = v[15 - i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ============================================================================
// Module   : usb_crc16
// Brief    : Bit-serial USB CRC16 over data bits presented LSB-first.
//            crc_out bit 0 (complemented) is the first CRC bit on the wire.
//            Used only when USB_TX_CRC16_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module usb_crc16
   import usb_tx_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clear,
   input  logic        enable,
   input  logic        bit_in,
   output logic [15:0] crc_out
);

   localparam logic [15:0] c_poly_refl = reflect16(CRC16_POLY);

   logic [15:0] r_crc;

   // Preset on reset or packet start, otherwise fold in one data bit per enable
   always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
         r_crc <= CRC16_INIT;
      end else if (enable) begin
         r_crc <= (r_crc >> 1) ^ ((r_crc[0] ^ bit_in) ? c_poly_refl : 16'h0000);
      end
   end

   assign crc_out = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_serializer
// Brief    : Full-speed USB line transmitter. Byte valid/ready input with a
//            one-byte holding register; emits SYNC, LSB-first bit-stuffed
//            NRZI data and an SE0/J end-of-packet on d_plus/d_minus.
//            Optional feature macro: USB_TX_CRC16_EN (append data CRC16).
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_serializer
   import usb_tx_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 8,
   parameter logic [7:0] SYNC_PATTERN = 8'h80,
   parameter int         STUFF_LIMIT  = 6,
   parameter int         EOP_SE0_BITS = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       busy,
   output logic       underrun
);

   localparam int c_tw = $clog2(CLKS_PER_BIT);
   localparam int c_sw = $clog2(STUFF_LIMIT + 1);
   localparam int c_ew = $clog2(EOP_SE0_BITS + 1);
`ifdef USB_TX_CRC16_EN
   localparam int c_bw = 4;   // bit index also walks the 16 CRC bits
`else
   localparam int c_bw = 3;
`endif

   tx_state_t        r_state, w_state_n;
   logic [c_tw-1:0]  r_timer, w_timer_n;
   logic [c_bw-1:0]  r_bitcnt, w_bitcnt_n, w_nidx, w_last_idx;
   logic [7:0]       r_shift, w_shift_n;
   logic             r_cur_last, w_last_n;
   logic [c_sw-1:0]  r_stuff, w_stuff_n;
   logic [c_ew-1:0]  r_eopcnt, w_eopcnt_n;
   logic             r_nrzi, w_nrzi_n;      // 1 = J, 0 = K
   logic             r_se0, w_se0_n;
   logic             r_underrun, w_underrun;
   logic [7:0]       r_hold;
   logic             r_hold_last, r_full;
   logic             w_bnd, w_drain, w_send, w_bit, w_nbit, w_eop;

`ifdef USB_TX_CRC16_EN
   logic             w_crc_clr, w_crc_en;
   logic [15:0]      w_crc;

   usb_crc16 u_crc16 (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (w_crc_clr),
      .enable  (w_crc_en),
      .bit_in  (w_bit),
      .crc_out (w_crc)
   );
`endif

   assign w_bnd    = (r_timer == c_tw'(CLKS_PER_BIT - 1));
   assign w_nidx   = r_bitcnt + c_bw'(1);
   assign tx_ready = !r_full;
   assign busy     = (r_state != ST_IDLE);
   assign underrun = r_underrun;
   assign {d_plus, d_minus} = r_se0 ? LINE_SE0 : (r_nrzi ? LINE_J : LINE_K);

   // Select the next unstuffed bit of the current field and its final index
   always_comb begin
      w_nbit     = 1'b0;
      w_last_idx = c_bw'(7);
      case (r_state)
         ST_SYNC: w_nbit = SYNC_PATTERN[w_nidx[2:0]];
         ST_DATA: w_nbit = r_shift[w_nidx[2:0]];
`ifdef USB_TX_CRC16_EN
         ST_CRC: begin
            w_nbit     = ~w_crc[w_nidx];
            w_last_idx = c_bw'(15);
         end
`endif
         default: w_nbit = 1'b0;
      endcase
   end

   // Next-state logic: decide the symbol for the coming bit period at each boundary
   always_comb begin
      w_state_n  = r_state;
      w_timer_n  = w_bnd ? '0 : r_timer + c_tw'(1);
      w_bitcnt_n = r_bitcnt;
      w_shift_n  = r_shift;
      w_last_n   = r_cur_last;
      w_stuff_n  = r_stuff;
      w_eopcnt_n = r_eopcnt;
      w_nrzi_n   = r_nrzi;
      w_se0_n    = r_se0;
      w_underrun = 1'b0;
      w_drain    = 1'b0;
      w_send     = 1'b0;
      w_bit      = 1'b0;
      w_eop      = 1'b0;
`ifdef USB_TX_CRC16_EN
      w_crc_clr  = 1'b0;
      w_crc_en   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            w_timer_n = '0;
            if (r_full) begin
               w_state_n  = ST_SYNC;
               w_bitcnt_n = '0;
               w_send     = 1'b1;
               w_bit      = SYNC_PATTERN[0];
`ifdef USB_TX_CRC16_EN
               w_crc_clr  = 1'b1;
`endif
            end
         end
         ST_SYNC, ST_DATA
`ifdef USB_TX_CRC16_EN
         , ST_CRC
`endif
         : begin
            if (w_bnd) begin
               if (r_stuff == c_sw'(STUFF_LIMIT)) begin
                  // Stuffed zero: the bit pointer stalls for one period
                  w_send = 1'b1;
                  w_bit  = 1'b0;
               end else if (r_bitcnt != w_last_idx) begin
                  w_bitcnt_n = w_nidx;
                  w_send     = 1'b1;
                  w_bit      = w_nbit;
`ifdef USB_TX_CRC16_EN
                  w_crc_en   = (r_state == ST_DATA);
`endif
               end else if (r_state == ST_SYNC ||
                            (r_state == ST_DATA && !r_cur_last && r_full)) begin
                  // Byte boundary with a byte waiting: drain the holding register
                  w_state_n  = ST_DATA;
                  w_bitcnt_n = '0;
                  w_shift_n  = r_hold;
                  w_last_n   = r_hold_last;
                  w_drain    = 1'b1;
                  w_send     = 1'b1;
                  w_bit      = r_hold[0];
`ifdef USB_TX_CRC16_EN
                  w_crc_en   = 1'b1;
`endif
               end else if (r_state == ST_DATA && r_cur_last) begin
`ifdef USB_TX_CRC16_EN
                  w_state_n  = ST_CRC;
                  w_bitcnt_n = '0;
                  w_send     = 1'b1;
                  w_bit      = ~w_crc[0];
`else
                  w_eop      = 1'b1;
`endif
               end else begin
                  // CRC done, or data ran dry without a last byte (truncation)
                  w_underrun = (r_state == ST_DATA);
                  w_eop      = 1'b1;
               end
            end
         end
         ST_EOP_SE0: begin
            if (w_bnd) begin
               if (r_eopcnt == c_ew'(EOP_SE0_BITS - 1)) begin
                  w_state_n = ST_EOP_J;
                  w_se0_n   = 1'b0;
                  w_nrzi_n  = 1'b1;
               end else begin
                  w_eopcnt_n = r_eopcnt + c_ew'(1);
               end
            end
         end
         ST_EOP_J: begin
            if (w_bnd) begin
               w_state_n = ST_IDLE;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase

      if (w_eop) begin
         w_state_n  = ST_EOP_SE0;
         w_se0_n    = 1'b1;
         w_eopcnt_n = '0;
         w_stuff_n  = '0;
      end

      // NRZI: a zero toggles the line, a one holds it and extends the run of ones
      if (w_send) begin
         w_se0_n = 1'b0;
         if (w_bit) begin
            w_stuff_n = r_stuff + c_sw'(1);
         end else begin
            w_stuff_n = '0;
            w_nrzi_n  = !r_nrzi;
         end
      end
   end

   // Serializer state, bit timer and line registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_cur_last <= 1'b0;
         r_stuff    <= '0;
         r_eopcnt   <= '0;
         r_nrzi     <= 1'b1;
         r_se0      <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_timer    <= w_timer_n;
         r_bitcnt   <= w_bitcnt_n;
         r_shift    <= w_shift_n;
         r_cur_last <= w_last_n;
         r_stuff    <= w_stuff_n;
         r_eopcnt   <= w_eopcnt_n;
         r_nrzi     <= w_nrzi_n;
         r_se0      <= w_se0_n;
         r_underrun <= w_underrun;
      end
   end

   // Holding register: a drain empties it; a load is only possible while empty
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_full      <= 1'b0;
         r_hold      <= '0;
         r_hold_last <= 1'b0;
      end else if (w_drain) begin
         r_full <= 1'b0;
      end else if (tx_valid && !r_full) begin
         r_full      <= 1'b1;
         r_hold      <= tx_data;
         r_hold_last <= tx_last;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_serializer
// Brief    : Scoreboard bench for usb_tx_serializer. Stimulus queues the
//            expected line symbol string per packet; a monitor samples each
//            bit period mid-symbol and compares. Honours USB_TX_CRC16_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_serializer;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       d_plus;
   logic       d_minus;
   logic       busy;
   logic       underrun;

   usb_tx_serializer dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .d_plus   (d_plus),
      .d_minus  (d_minus),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      string syms;     // J, K or 0 (SE0) per bit period
      int    ur_idx;   // symbol index where underrun pulses, -1 for none
      int    start;    // edge count of the first-byte handshake
      bit    abort;    // packet is cut by reset after the listed symbols
   } pkt_t;

   pkt_t exp_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   pcyc       = 0;
   bit   mon_active = 1'b0;
   logic prev_busy  = 1'b0;

   always @(posedge clk) pcyc <= pcyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_sym(input string name, input byte act, input byte exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %c expected %c", name, act, exp);
      end
   endtask

   function automatic byte line_sym();
      case ({d_plus, d_minus})
         2'b10:   return "J";
         2'b01:   return "K";
         2'b00:   return "0";
         default: return "X";
      endcase
   endfunction

   // Reference CRC field symbols (byte-wise reflected CRC16, stuffing, NRZI)
   function automatic string crc_tail(input logic [15:0] pl, input int nb,
                                      input bit end_j, input int ones_in);
      logic [15:0] c;
      logic [15:0] t;
      string       s;
      string       ch;
      bit          lj;
      int          ones;
      c = 16'hFFFF; lj = end_j; ones = ones_in; s = "";
      for (int i = 0; i < nb; i++) begin
         c = c ^ {8'h00, pl[8*i +: 8]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      t = ~c;
      for (int i = 0; i < 16; i++) begin
         if (!t[i]) begin lj = !lj; ones = 0; end
         else ones++;
         ch = lj ? "J" : "K"; s = {s, ch};
         if (ones == 6) begin
            lj = !lj; ones = 0; ch = lj ? "J" : "K"; s = {s, ch};
         end
      end
`ifdef USB_TX_CRC16_EN
      return s;
`else
      return "";
`endif
   endfunction

   task automatic push(input string name, input string syms, input int ur_idx,
                       input int start, input bit abort);
      pkt_t p;
      p.name = name; p.syms = syms; p.ur_idx = ur_idx; p.start = start; p.abort = abort;
      exp_q.push_back(p);
   endtask

   // Compare one packet symbol by symbol, starting the negedge after busy rises
   task automatic run_packet(input pkt_t e);
      int n        = e.syms.len();
      int ur_first = -1;
      int ur_cnt   = 0;
      chk($sformatf("%s_start_latency", e.name), pcyc - e.start, 1);
      for (int k = 0; k <= n * 8; k++) begin
         if (k > 0) @(negedge clk);
         if (underrun === 1'b1) begin
            if (ur_first < 0) ur_first = k;
            ur_cnt++;
         end
         if (k % 8 == 3) begin
            chk_sym($sformatf("%s_sym%0d", e.name, k / 8), line_sym(), e.syms[k / 8]);
            if (e.abort && (k / 8 == n - 1)) return;
         end
         if (k == n * 8 - 1) chk($sformatf("%s_busy_last", e.name), int'(busy), 1);
         if (k == n * 8)     chk($sformatf("%s_busy_fall", e.name), int'(busy), 0);
      end
      chk($sformatf("%s_underrun_pos", e.name), ur_first, (e.ur_idx < 0) ? -1 : e.ur_idx * 8);
      chk($sformatf("%s_underrun_cnt", e.name), ur_cnt, (e.ur_idx < 0) ? 0 : 1);
   endtask

   // Monitor: each rising busy opens the next expected packet
   initial begin : monitor
      pkt_t e;
      forever begin
         @(negedge clk);
         if (n_rst && busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_packet", 1, 0);
            end else begin
               e = exp_q.pop_front();
               mon_active = 1'b1;
               run_packet(e);
               mon_active = 1'b0;
            end
         end
         prev_busy = busy;
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic l, output int hs);
      int n = 0;
      tx_data = d; tx_valid = 1'b1; tx_last = l;
      while (!tx_ready && n < 400) begin @(negedge clk); n++; end
      if (!tx_ready) chk("accept_timeout", 1, 0);
      @(negedge clk);
      hs = pcyc;
      tx_valid = 1'b0;
      chk("ready_low_after_accept", int'(tx_ready), 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || mon_active || exp_q.size() != 0) && n < 1500) begin
         @(negedge clk); n++;
      end
      if (n >= 1500) chk("idle_timeout", 1, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin : stim
      int hs, hs2, n;
      n_rst = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_dplus", int'(d_plus), 1);
      chk("rst_dminus", int'(d_minus), 0);
      chk("rst_ready", int'(tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_underrun", int'(underrun), 0);
      n_rst = 1'b1;
      @(negedge clk);

      // Single zero byte: alternating line, 19 bit periods in total
      send_byte(8'h00, 1'b1, hs);
      push("t1_zero", {"KJKJKJKK", "JKJKJKJK", crc_tail(16'h0000, 1, 1'b0, 0), "00J"}, -1, hs, 1'b0);
      wait_idle();

      // All ones: stuffed K->J after six ones, data field is 9 periods
      send_byte(8'hFF, 1'b1, hs);
      push("t2_ff", {"KJKJKJKK", "KKKKKJJJJ", crc_tail(16'h00FF, 1, 1'b1, 3), "00J"}, -1, hs, 1'b0);
      wait_idle();

      // Streaming two bytes with valid held
      send_byte(8'hA5, 1'b0, hs);
      push("t3_stream", {"KJKJKJKK", "KJJKJJKK", "JKKKKKJK", crc_tail(16'h3CA5, 2, 1'b0, 0), "00J"},
           -1, hs, 1'b0);
      send_byte(8'h3C, 1'b1, hs2);
      chk("t3_second_accept", hs2 - hs, 66);
      n = 0;
      while (!tx_ready && n < 300) begin @(negedge clk); n++; end
      chk("t3_ready_rise", pcyc - hs2, 63);
      wait_idle();

      // Data runs dry without a last byte: underrun then SE0 SE0 J
      send_byte(8'h00, 1'b0, hs);
      push("t4_underrun", {"KJKJKJKK", "JKJKJKJK", "00J"}, 16, hs, 1'b0);
      wait_idle();

      // One-cycle reset in the middle of the data field
      send_byte(8'h00, 1'b1, hs);
      push("t5_abort", "KJKJKJKKJK", -1, hs, 1'b1);
      repeat (89) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_dplus", int'(d_plus), 1);
      chk("t5_rst_dminus", int'(d_minus), 0);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_ready", int'(tx_ready), 1);
      chk("t5_rst_underrun", int'(underrun), 0);
      n_rst = 1'b1;
      @(negedge clk);
      send_byte(8'h00, 1'b1, hs);
      push("t5_restart", {"KJKJKJKK", "JKJKJKJK", crc_tail(16'h0000, 1, 1'b0, 0), "00J"}, -1, hs, 1'b0);
      wait_idle();

      // Payload 00 01: CRC field when enabled, straight to EOP otherwise
      send_byte(8'h00, 1'b0, hs);
      push("t6_crc", {"KJKJKJKK", "JKJKJKJK", "KJKJKJKJ", crc_tail(16'h0100, 2, 1'b1, 0), "00J"},
           -1, hs, 1'b0);
      send_byte(8'h01, 1'b1, hs2);
      wait_idle();

      chk("leftover_expected", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
